// File: rtl/except_ctrl_if.sv
// Bundle between the MEM stage / cp0_reg and the exception scheduler.
// The pipeline side drives through master; except_ctrl connects as slave.
interface except_ctrl_if;
  // MEM-stage instruction
  logic        mem_valid_i;
  logic        mem_stall_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_addr_i;
  logic        mem_in_ds_i;
  logic [8:0]  mem_exc_i;

  // Architectural CP0 state, plus the WB-stage MTC0 that may overwrite it
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  // Toward cp0_reg and the fetch / flush logic
  logic [31:0] except_type_o;
  logic [31:0] except_pc_o;
  logic        except_ds_o;
  logic [31:0] except_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        redirect_o;
  logic        busy_o;

  modport master (
    output mem_valid_i, mem_stall_i, mem_pc_i, mem_addr_i, mem_in_ds_i, mem_exc_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  except_type_o, except_pc_o, except_ds_o, except_addr_o,
    input  flush_o, new_pc_o, redirect_o, busy_o
  );

  modport slave (
    input  mem_valid_i, mem_stall_i, mem_pc_i, mem_addr_i, mem_in_ds_i, mem_exc_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output except_type_o, except_pc_o, except_ds_o, except_addr_o,
    output flush_o, new_pc_o, redirect_o, busy_o
  );
endinterface

// File: rtl/except_ctrl.sv
// Exception/interrupt scheduler between MEM and cp0_reg: prioritises exceptions,
// redirects fetch and holds the pipeline flush for FLUSH_CYCLES cycles.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR_BEV = 32'hBFC0_0380,
  parameter logic [31:0] EXC_VECTOR     = 32'h8000_0180,
  parameter int          FLUSH_CYCLES   = 2
) (
  input  logic         clk,
  input  logic         rst,
  except_ctrl_if.slave bus
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] EXC_NONE  = 32'h00;
  localparam logic [31:0] EXC_INT   = 32'h01;
  localparam logic [31:0] EXC_ADEL  = 32'h04;
  localparam logic [31:0] EXC_ADES  = 32'h05;
  localparam logic [31:0] EXC_SYS   = 32'h08;
  localparam logic [31:0] EXC_BRK   = 32'h09;
  localparam logic [31:0] EXC_RI    = 32'h0a;
  localparam logic [31:0] EXC_OV    = 32'h0c;
  localparam logic [31:0] EXC_TRAP  = 32'h0d;
  localparam logic [31:0] EXC_ERET  = 32'h0e;
  localparam logic [31:0] EXC_FADEL = 32'h0f;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pend;
  logic        take;
  logic [31:0] exc_code;
  logic        redirect;

  // The MTC0 sitting in WB commits this cycle, so its value is the one that counts.
  always_comb begin
    eff_status = bus.cp0_status_i;
    eff_cause  = bus.cp0_cause_i;
    eff_epc    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      if (bus.wb_cp0_waddr_i == CP0_STATUS) eff_status = bus.wb_cp0_data_i;
      if (bus.wb_cp0_waddr_i == CP0_CAUSE)  eff_cause[9:8] = bus.wb_cp0_data_i[9:8];
      if (bus.wb_cp0_waddr_i == CP0_EPC)    eff_epc = bus.wb_cp0_data_i;
    end
  end

  assign int_pend = (|(eff_cause[15:8] & eff_status[15:8])) & eff_status[0] & ~eff_status[1];

  assign take = rst && (state_q == IDLE) && bus.mem_valid_i && !bus.mem_stall_i;

  // NOTE: every variable driven in always_comb gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    exc_code = EXC_NONE;
    if (take) begin
      if      (int_pend)          exc_code = EXC_INT;
      else if (bus.mem_exc_i[8])  exc_code = EXC_FADEL;
      else if (bus.mem_exc_i[7])  exc_code = EXC_RI;
      else if (bus.mem_exc_i[6])  exc_code = EXC_SYS;
      else if (bus.mem_exc_i[5])  exc_code = EXC_BRK;
      else if (bus.mem_exc_i[4])  exc_code = EXC_TRAP;
      else if (bus.mem_exc_i[3])  exc_code = EXC_OV;
      else if (bus.mem_exc_i[2])  exc_code = EXC_ADEL;
      else if (bus.mem_exc_i[1])  exc_code = EXC_ADES;
      else if (bus.mem_exc_i[0])  exc_code = EXC_ERET;
    end
  end

  assign redirect = (exc_code != EXC_NONE);

  // Flush lasts FLUSH_CYCLES in total: the redirect cycle plus FLUSH_CYCLES-1 in FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (redirect && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.except_type_o = exc_code;
  assign bus.except_pc_o   = take ? bus.mem_pc_i   : 32'h0;
  assign bus.except_ds_o   = take & bus.mem_in_ds_i;
  assign bus.except_addr_o = take ? bus.mem_addr_i : 32'h0;
  assign bus.redirect_o    = redirect;
  assign bus.flush_o       = rst & (redirect | (state_q == FLUSH));
  assign bus.busy_o        = rst & (state_q == FLUSH);

  always_comb begin
    bus.new_pc_o = 32'h0;
    if (redirect) begin
      if (exc_code == EXC_ERET) bus.new_pc_o = eff_epc;
      else                      bus.new_pc_o = eff_status[22] ? EXC_VECTOR_BEV : EXC_VECTOR;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{eff_status[31:23], eff_status[21:16], eff_status[7:2],
                         eff_cause[31:16], eff_cause[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: priority, forwarding, flush sequencing,
// stall/bubble suppression and reset during FLUSH.
module tb_except_ctrl;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  except_ctrl_if bus ();

  except_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_valid_i    = 1'b0;
    bus.mem_stall_i    = 1'b0;
    bus.mem_pc_i       = 32'h0;
    bus.mem_addr_i     = 32'h0;
    bus.mem_in_ds_i    = 1'b0;
    bus.mem_exc_i      = 9'h0;
    bus.cp0_status_i   = 32'h0;
    bus.cp0_cause_i    = 32'h0;
    bus.cp0_epc_i      = 32'h0;
    bus.wb_cp0_we_i    = 1'b0;
    bus.wb_cp0_waddr_i = 5'd0;
    bus.wb_cp0_data_i  = 32'h0;
  endtask

  initial begin
    // Reset: outputs held at zero even with an exception presented
    idle_inputs();
    rst = 1'b0;
    bus.mem_valid_i  = 1'b1;
    bus.mem_exc_i    = 9'h040;
    bus.cp0_status_i = 32'h0040_0000;
    #1;
    check("rst_type",     bus.except_type_o, 32'h0);
    check("rst_redirect", {31'h0, bus.redirect_o}, 32'h0);
    check("rst_flush",    {31'h0, bus.flush_o}, 32'h0);
    check("rst_busy",     {31'h0, bus.busy_o}, 32'h0);
    tick();
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("idle_type", bus.except_type_o, 32'h0);

    // 1: syscall with BEV=1
    tick();
    bus.cp0_status_i = 32'h0040_0000;
    bus.mem_valid_i  = 1'b1;
    bus.mem_exc_i    = 9'h040;
    bus.mem_pc_i     = 32'h8000_1234;
    bus.mem_addr_i   = 32'h0000_0abc;
    #1;
    check("sys_type",     bus.except_type_o, 32'h08);
    check("sys_newpc",    bus.new_pc_o, 32'hBFC0_0380);
    check("sys_redirect", {31'h0, bus.redirect_o}, 32'h1);
    check("sys_flush0",   {31'h0, bus.flush_o}, 32'h1);
    check("sys_pc",       bus.except_pc_o, 32'h8000_1234);
    check("sys_addr",     bus.except_addr_o, 32'h0000_0abc);
    tick();
    bus.mem_valid_i = 1'b0;
    bus.mem_exc_i   = 9'h0;
    #1;
    check("sys_redirect1", {31'h0, bus.redirect_o}, 32'h0);
    check("sys_flush1",    {31'h0, bus.flush_o}, 32'h1);
    check("sys_busy1",     {31'h0, bus.busy_o}, 32'h1);
    tick();
    #1;
    check("sys_flush2", {31'h0, bus.flush_o}, 32'h0);
    check("sys_busy2",  {31'h0, bus.busy_o}, 32'h0);

    // 2: interrupt beats overflow, delay-slot flag passes through, BEV=0 vector
    tick();
    bus.cp0_status_i = 32'h0000_8001;
    bus.cp0_cause_i  = 32'h0000_8000;
    bus.mem_valid_i  = 1'b1;
    bus.mem_in_ds_i  = 1'b1;
    bus.mem_exc_i    = 9'h008;
    #1;
    check("int_type",  bus.except_type_o, 32'h01);
    check("int_ds",    {31'h0, bus.except_ds_o}, 32'h1);
    check("int_newpc", bus.new_pc_o, 32'h8000_0180);
    tick();
    idle_inputs();
    tick();

    // 3: ERET with EPC forwarded from WB
    tick();
    bus.cp0_epc_i      = 32'h0000_1000;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = 5'd14;
    bus.wb_cp0_data_i  = 32'h0000_2000;
    bus.mem_valid_i    = 1'b1;
    bus.mem_exc_i      = 9'h001;
    #1;
    check("eret_type",  bus.except_type_o, 32'h0e);
    check("eret_newpc", bus.new_pc_o, 32'h0000_2000);
    tick();
    idle_inputs();
    tick();

    // 4: adel, then ri arrives during FLUSH and is dropped
    tick();
    bus.mem_valid_i = 1'b1;
    bus.mem_exc_i   = 9'h004;
    #1;
    check("adel_type", bus.except_type_o, 32'h04);
    tick();
    bus.mem_exc_i = 9'h080;
    #1;
    check("ri_ignored", bus.except_type_o, 32'h0);
    check("ri_busy",    {31'h0, bus.busy_o}, 32'h1);
    check("ri_redir",   {31'h0, bus.redirect_o}, 32'h0);
    tick();
    bus.mem_valid_i = 1'b0;
    bus.mem_exc_i   = 9'h0;
    #1;
    check("ri_busy_done", {31'h0, bus.busy_o}, 32'h0);

    // Priority spot checks: fetch_adel over ri, trap over ov, ades alone
    tick();
    bus.mem_valid_i = 1'b1;
    bus.mem_exc_i   = 9'h180;
    #1;
    check("fadel_prio", bus.except_type_o, 32'h0f);
    tick();
    bus.mem_valid_i = 1'b0;
    tick();
    bus.mem_valid_i = 1'b1;
    bus.mem_exc_i   = 9'h018;
    #1;
    check("trap_prio", bus.except_type_o, 32'h0d);
    tick();
    bus.mem_valid_i = 1'b0;
    tick();
    bus.mem_valid_i = 1'b1;
    bus.mem_exc_i   = 9'h002;
    #1;
    check("ades_type", bus.except_type_o, 32'h05);
    tick();
    idle_inputs();
    tick();

    // Bubble with a pending interrupt is not taken
    tick();
    bus.cp0_status_i = 32'h0000_8001;
    bus.cp0_cause_i  = 32'h0000_8000;
    #1;
    check("bubble_type", bus.except_type_o, 32'h0);

    // 5: stall suppresses the interrupt for three cycles
    bus.mem_valid_i = 1'b1;
    bus.mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_type", bus.except_type_o, 32'h0);
      tick();
    end
    bus.mem_stall_i = 1'b0;
    #1;
    check("unstall_type", bus.except_type_o, 32'h01);
    tick();
    bus.mem_valid_i = 1'b0;
    tick();

    // 6: MTC0 Status with IE=0 in WB masks the pending interrupt
    bus.mem_valid_i    = 1'b1;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = 5'd12;
    bus.wb_cp0_data_i  = 32'h0000_8000;
    #1;
    check("fwd_ie_type", bus.except_type_o, 32'h0);
    check("fwd_ie_redir", {31'h0, bus.redirect_o}, 32'h0);

    // Reset while in FLUSH
    tick();
    bus.wb_cp0_we_i = 1'b0;
    #1;
    check("int2_type", bus.except_type_o, 32'h01);
    tick();
    bus.mem_valid_i = 1'b0;
    #1;
    check("int2_busy", {31'h0, bus.busy_o}, 32'h1);
    rst = 1'b0;
    #1;
    check("rstflush_flush", {31'h0, bus.flush_o}, 32'h0);
    check("rstflush_busy",  {31'h0, bus.busy_o}, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("after_rst_flush", {31'h0, bus.flush_o}, 32'h0);
    check("after_rst_redir", {31'h0, bus.redirect_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
